// File: rtl/lmem_decode_sequencer.sv
// Lmem control sequencer for the layered LDPC decoder.
// Walks each codeword through load, per-layer read/write processing,
// hard-decision unload and a completion pulse.
module lmem_decode_sequencer #(
   parameter int unsigned ROWDEPTH    = 20,
   parameter int unsigned ROWWIDTH    = 5,
   parameter int unsigned LAYERS      = 2,
   parameter int unsigned LAYERWIDTH  = 1,
   parameter int unsigned PIPESTAGES  = 15,
   parameter int unsigned LOADBEATS   = 17,
   parameter int unsigned UNLOADDEPTH = 16,
   parameter int unsigned MAXITRS     = 10,
   parameter int unsigned ITRWIDTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ITRWIDTH-1:0]   max_itr,
   input  logic                  load_valid,
   input  logic                  early_term,
   output logic                  load_ready,
   output logic                  loaden,
   output logic                  rd_en,
   output logic [ROWWIDTH-1:0]   rd_address,
   output logic [LAYERWIDTH-1:0] rd_layer,
   output logic                  wr_en,
   output logic [ROWWIDTH-1:0]   wr_address,
   output logic [LAYERWIDTH-1:0] wr_layer,
   output logic                  firstprocessing_indicate,
   output logic                  unload_en,
   output logic [ROWWIDTH-1:0]   unloadAddress,
   output logic [ITRWIDTH-1:0]   itr,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BEATW = $clog2(LOADBEATS + 1);

   localparam logic [ROWWIDTH-1:0]   LAST_ADDR   = ROWWIDTH'(ROWDEPTH - 1);
   localparam logic [ROWWIDTH-1:0]   LAST_UNLOAD = ROWWIDTH'(UNLOADDEPTH - 1);
   localparam logic [LAYERWIDTH-1:0] LAST_LAYER  = LAYERWIDTH'(LAYERS - 1);
   localparam logic [BEATW-1:0]      LAST_BEAT   = BEATW'(LOADBEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PROC,
      S_DRAIN,
      S_UNLOAD,
      S_DONE
   } state_t;

   typedef struct packed {
      logic                  en;
      logic [ROWWIDTH-1:0]   addr;
      logic [LAYERWIDTH-1:0] layer;
   } rd_beat_t;

   state_t                state;
   logic [ITRWIDTH-1:0]   lim;
   logic [ITRWIDTH-1:0]   itr_next;
   logic [BEATW-1:0]      beat_cnt;
   rd_beat_t              dline [PIPESTAGES];

   assign itr_next   = itr + 1'b1;
   assign load_ready = (state == S_LOAD);
   assign loaden     = load_ready & load_valid;

   assign wr_en      = dline[PIPESTAGES-1].en;
   assign wr_address = dline[PIPESTAGES-1].addr;
   assign wr_layer   = dline[PIPESTAGES-1].layer;

   // Read-to-write delay line matching the RCU pipeline; shifts every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(PIPESTAGES); i++) dline[i] <= '0;
      end else begin
         dline[0] <= '{en: rd_en, addr: rd_address, layer: rd_layer};
         for (int i = 1; i < int'(PIPESTAGES); i++) dline[i] <= dline[i-1];
      end
   end

   // Phase sequencing with registered Lmem controls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                    <= S_IDLE;
         lim                      <= '0;
         beat_cnt                 <= '0;
         rd_en                    <= 1'b0;
         rd_address               <= '0;
         rd_layer                 <= '0;
         firstprocessing_indicate <= 1'b0;
         unload_en                <= 1'b0;
         unloadAddress            <= '0;
         itr                      <= '0;
         busy                     <= 1'b0;
         done                     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LOAD;
                  busy     <= 1'b1;
                  itr      <= '0;
                  beat_cnt <= '0;
                  if (max_itr == '0)                     lim <= ITRWIDTH'(1);
                  else if (max_itr > ITRWIDTH'(MAXITRS)) lim <= ITRWIDTH'(MAXITRS);
                  else                                   lim <= max_itr;
               end
            end
            S_LOAD: begin
               if (load_valid) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state                    <= S_PROC;
                     rd_en                    <= 1'b1;
                     rd_address               <= '0;
                     rd_layer                 <= '0;
                     itr                      <= '0;
                     firstprocessing_indicate <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            S_PROC: begin
               if (rd_address == LAST_ADDR) begin
                  state <= S_DRAIN;
                  rd_en <= 1'b0;
               end else begin
                  rd_address <= rd_address + 1'b1;
               end
            end
            S_DRAIN: begin
               // Hold reads until the layer's last write leaves the pipeline.
               if (wr_en && (wr_address == LAST_ADDR)) begin
                  if (rd_layer != LAST_LAYER) begin
                     state      <= S_PROC;
                     rd_en      <= 1'b1;
                     rd_address <= '0;
                     rd_layer   <= rd_layer + 1'b1;
                  end else if (early_term || (itr_next == lim)) begin
                     state                    <= S_UNLOAD;
                     unload_en                <= 1'b1;
                     unloadAddress            <= '0;
                     firstprocessing_indicate <= 1'b0;
                  end else begin
                     state                    <= S_PROC;
                     itr                      <= itr_next;
                     rd_en                    <= 1'b1;
                     rd_address               <= '0;
                     rd_layer                 <= '0;
                     firstprocessing_indicate <= 1'b0;
                  end
               end
            end
            S_UNLOAD: begin
               if (unloadAddress == LAST_UNLOAD) begin
                  state     <= S_DONE;
                  unload_en <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  unloadAddress <= unloadAddress + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lmem_decode_sequencer.sv
// Bench for lmem_decode_sequencer: table of decode scenarios plus random runs,
// each cycle checked against a timeline computed from layer/iteration arithmetic.
module tb_lmem_decode_sequencer;

   localparam int ROWDEPTH    = 20;
   localparam int ROWWIDTH    = 5;
   localparam int LAYERWIDTH  = 1;
   localparam int PIPESTAGES  = 15;
   localparam int LOADBEATS   = 17;
   localparam int UNLOADDEPTH = 16;
   localparam int MAXITRS     = 10;
   localparam int ITRWIDTH    = 4;
   localparam int LAYERCYC    = ROWDEPTH + PIPESTAGES;
   localparam int ITRCYC      = 2 * LAYERCYC;
   localparam int UNDECIDED   = 32'h3fff_ffff;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  start = 1'b0;
   logic [ITRWIDTH-1:0]   max_itr = '0;
   logic                  load_valid = 1'b0;
   logic                  early_term = 1'b0;
   logic                  load_ready, loaden, rd_en, wr_en;
   logic [ROWWIDTH-1:0]   rd_address, wr_address, unloadAddress;
   logic [LAYERWIDTH-1:0] rd_layer, wr_layer;
   logic                  firstprocessing_indicate, unload_en, busy, done;
   logic [ITRWIDTH-1:0]   itr;

   typedef struct {
      int mi;
      int gap;      // percent of idle load cycles, -1 = strict 1,0 toggle
      int et_iter;  // iteration whose end sees early_term=1, -1 = never
      int noise;    // percent early_term elsewhere (must be ignored)
      int exp_n;    // iterations expected
   } vec_t;

   vec_t vecs [8];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   last_itr = 0;

   lmem_decode_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .max_itr(max_itr),
      .load_valid(load_valid), .early_term(early_term),
      .load_ready(load_ready), .loaden(loaden),
      .rd_en(rd_en), .rd_address(rd_address), .rd_layer(rd_layer),
      .wr_en(wr_en), .wr_address(wr_address), .wr_layer(wr_layer),
      .firstprocessing_indicate(firstprocessing_indicate),
      .unload_en(unload_en), .unloadAddress(unloadAddress),
      .itr(itr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_tests++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Read issued at offset k from the first processing cycle.
   function automatic void rd_at(input int k, input int end_k, output bit en,
                                 output int addr, output int layer);
      en = 1'b0; addr = 0; layer = 0;
      if (k >= 0 && k < end_k) begin
         addr  = k % LAYERCYC;
         layer = (k % ITRCYC) / LAYERCYC;
         en    = (addr < ROWDEPTH);
      end
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},  32'(load_ready), 0);
      chk({tag, "_loaden"}, 32'(loaden), 0);
      chk({tag, "_rd_en"},  32'(rd_en), 0);
      chk({tag, "_rd_addr"},32'(rd_address), 0);
      chk({tag, "_wr_en"},  32'(wr_en), 0);
      chk({tag, "_wr_addr"},32'(wr_address), 0);
      chk({tag, "_fpi"},    32'(firstprocessing_indicate), 0);
      chk({tag, "_unload"}, 32'(unload_en), 0);
      chk({tag, "_itr"},    32'(itr), 0);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_done"},   32'(done), 0);
   endtask

   task automatic run_decode(input vec_t v, input int abort_k);
      int  lim, beats, k, n, cyc, end_k;
      bit  loading, finished, toggle, idle_next, e_un;
      bit  e_rd, e_wr;
      int  e_ra, e_rl, e_wa, e_wl;
      int  c_ld, c_rd, c_fpi, c_un, c_dn;
      lim = (v.mi == 0) ? 1 : ((v.mi > MAXITRS) ? MAXITRS : v.mi);
      beats = 0; k = -1; n = 0; cyc = 0;
      loading = 1'b1; finished = 1'b0; toggle = 1'b1;
      c_ld = 0; c_rd = 0; c_fpi = 0; c_un = 0; c_dn = 0;

      // request cycle (IDLE)
      @(posedge clk); #1;
      start = 1'b1; max_itr = ITRWIDTH'(v.mi);
      load_valid = 1'($urandom); early_term = 1'($urandom);
      @(negedge clk);
      chk("req_busy",  32'(busy), 0);
      chk("req_ready", 32'(load_ready), 0);
      chk("req_itr",   32'(itr), last_itr);

      while (!finished) begin
         @(posedge clk); #1;
         cyc++;
         if (!loading) k++;
         end_k     = (n == 0) ? UNDECIDED : ITRCYC * n;
         idle_next = (n != 0) && (k >= end_k + UNLOADDEPTH);
         start     = !idle_next && ($urandom_range(99) < 5);
         max_itr   = ITRWIDTH'($urandom);
         if (loading) begin
            if (v.gap < 0) begin load_valid = toggle; toggle = !toggle; end
            else load_valid = ($urandom_range(99) >= v.gap);
         end else begin
            load_valid = 1'($urandom);
         end
         if (!loading && (k % ITRCYC == ITRCYC - 1)) early_term = (k / ITRCYC == v.et_iter);
         else early_term = ($urandom_range(99) < v.noise);

         if (!loading && k == abort_k) begin
            #1 rst = 1'b0;
            #1 chk_all_zero("rst_mid");
            start = 1'b0; load_valid = 1'b0; early_term = 1'b0;
            @(negedge clk); rst = 1'b1;
            @(negedge clk);
            chk_all_zero("rst_after");
            last_itr = 0;
            return;
         end

         @(negedge clk);
         if (loading) begin
            chk("load_ready", 32'(load_ready), 1);
            chk("loaden",     32'(loaden), 32'(load_valid));
            chk("load_rd_en", 32'(rd_en), 0);
            chk("load_wr_en", 32'(wr_en), 0);
            chk("load_fpi",   32'(firstprocessing_indicate), 0);
            chk("load_itr",   32'(itr), 0);
            chk("load_busy",  32'(busy), 1);
            chk("load_done",  32'(done), 0);
         end else begin
            rd_at(k, end_k, e_rd, e_ra, e_rl);
            rd_at(k - PIPESTAGES, end_k, e_wr, e_wa, e_wl);
            e_un = (n != 0) && (k >= end_k) && (k < end_k + UNLOADDEPTH);
            chk("ready",  32'(load_ready), 0);
            chk("loaden", 32'(loaden), 0);
            chk("rd_en",  32'(rd_en), 32'(e_rd));
            if (e_rd) begin
               chk("rd_address", 32'(rd_address), e_ra);
               chk("rd_layer",   32'(rd_layer), e_rl);
            end
            chk("wr_en",  32'(wr_en), 32'(e_wr));
            if (e_wr) begin
               chk("wr_address", 32'(wr_address), e_wa);
               chk("wr_layer",   32'(wr_layer), e_wl);
            end
            chk("fpi",       32'(firstprocessing_indicate), (k < ITRCYC) ? 1 : 0);
            chk("unload_en", 32'(unload_en), 32'(e_un));
            if (e_un) chk("unloadAddress", 32'(unloadAddress), k - end_k);
            chk("done", 32'(done), ((n != 0) && (k == end_k + UNLOADDEPTH)) ? 1 : 0);
            chk("itr",  32'(itr), (k < end_k) ? k / ITRCYC : n - 1);
            chk("busy", 32'(busy), 1);
         end
         c_ld  += 32'(loaden);
         c_rd  += 32'(rd_en);
         c_fpi += 32'(firstprocessing_indicate);
         c_un  += 32'(unload_en);
         c_dn  += 32'(done);

         if (loading) begin
            if (load_valid) begin
               beats++;
               if (beats == LOADBEATS) loading = 1'b0;
            end
         end else begin
            if (n == 0 && (k % ITRCYC == ITRCYC - 1) &&
                (early_term || (k / ITRCYC + 1 == lim))) n = k / ITRCYC + 1;
            if (n != 0 && k == ITRCYC * n + UNLOADDEPTH) finished = 1'b1;
         end
         if (cyc > 3000 && !finished) begin
            n_tests++; n_fail++;
            $display("FAIL run_timeout: got %0d cycles expected completion", cyc);
            finished = 1'b1;
         end
      end

      chk("cnt_loaden", 32'(c_ld),  LOADBEATS);
      chk("cnt_rd_en",  32'(c_rd),  2 * ROWDEPTH * v.exp_n);
      chk("cnt_fpi",    32'(c_fpi), ITRCYC);
      chk("cnt_unload", 32'(c_un),  UNLOADDEPTH);
      chk("cnt_done",   32'(c_dn),  1);

      @(posedge clk); #1;
      start = 1'b0; load_valid = 1'($urandom); early_term = 1'($urandom);
      @(negedge clk);
      chk("end_busy",  32'(busy), 0);
      chk("end_done",  32'(done), 0);
      chk("end_wr_en", 32'(wr_en), 0);
      chk("end_itr",   32'(itr), v.exp_n - 1);
      last_itr = v.exp_n - 1;
   endtask

   initial begin
      vec_t rv;
      int   rl;
      vecs[0] = '{2,  0, -1,  0,  2};   // nominal
      vecs[1] = '{3, -1, -1,  0,  3};   // toggled load beats
      vecs[2] = '{10, 0,  0, 20,  1};   // early stop after iteration 0
      vecs[3] = '{0, 30, -1, 20,  1};   // zero limit means one iteration
      vecs[4] = '{15, 0, -1, 20, 10};   // clamped to the ceiling
      vecs[5] = '{10, 20, 4, 30,  5};   // early stop mid-run
      vecs[6] = '{1,  0, -1, 50,  1};
      vecs[7] = '{5,  0, -1, 10,  5};   // aborted by reset

      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 7; i++) run_decode(vecs[i], -1);

      run_decode(vecs[7], 2 * ITRCYC + 30);
      run_decode(vecs[0], -1);

      for (int r = 0; r < 4; r++) begin
         rv.mi      = $urandom_range(15);
         rv.gap     = $urandom_range(60);
         rv.et_iter = ($urandom_range(1) == 1) ? $urandom_range(9) : -1;
         rv.noise   = 20;
         rl         = (rv.mi == 0) ? 1 : ((rv.mi > MAXITRS) ? MAXITRS : rv.mi);
         rv.exp_n   = (rv.et_iter >= 0 && rv.et_iter + 1 < rl) ? rv.et_iter + 1 : rl;
         run_decode(rv, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lmem_decode_sequencer.md
Name: lmem_decode_sequencer

Overview:
Top-level sequencer for the layered LDPC decoder's bit-node (LLR) memory. Per codeword it drives the Lmem ports through four phases:
- LOAD: codeword load.
- PROC: per-layer read/write processing across up to MAXITRS iterations, with writes lagging reads by the RCU pipeline depth.
- UNLOAD: hard-decision unload.
- DONE: completion pulse.
It sits between the decoder top and the Lmem/RCU datapath and owns every Lmem control signal.

Parameters:
- ROWDEPTH, 20, addresses per layer (ceil(Z/P)=ceil(511/26))
- ROWWIDTH, 5, address width
- LAYERS, 2, layers per iteration
- LAYERWIDTH, 1, layer index width
- PIPESTAGES, 15, read-to-write latency (memrd + 13 RCU stages + memwr)
- LOADBEATS, 17, load beats per codeword
- UNLOADDEPTH, 16, HD unload addresses (ceil(511*14/448))
- MAXITRS, 10, iteration ceiling
- ITRWIDTH, 4, iteration counter width

Ports:
- clk in 1 system clock, rising edge
- rst in 1 asynchronous active-low reset
- start in 1 one-cycle request to decode a codeword
- max_itr in ITRWIDTH iteration limit, sampled on accepted start
- load_valid in 1 load_data beat present this cycle
- early_term in 1 syndrome satisfied, sampled at iteration end
- load_ready out 1 sequencer is in LOAD
- loaden out 1 Lmem load enable
- rd_en out 1 Lmem read enable
- rd_address out ROWWIDTH Lmem read address
- rd_layer out LAYERWIDTH Lmem read layer
- wr_en out 1 Lmem write enable
- wr_address out ROWWIDTH write address (rd_address delayed)
- wr_layer out LAYERWIDTH Lmem write layer
- firstprocessing_indicate out 1 high throughout iteration 0
- unload_en out 1 Lmem unload enable
- unloadAddress out ROWWIDTH Lmem unload address
- itr out ITRWIDTH current iteration index
- busy out 1 not IDLE
- done out 1 one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, all counters 0, delay line cleared. Applies mid-operation; no write completes after reset.
- All outputs are registered. States: IDLE, LOAD, PROC, DRAIN, UNLOAD, DONE.
- IDLE: start=1 → LOAD.
  - Latch lim = (max_itr==0) ? 1 : min(max_itr, MAXITRS).
  - start is ignored in every other state.
- LOAD: load_ready=1 and loaden=load_valid (combinational from registered state; the single allowed exception).
  - Beat counter increments on load_valid.
  - A gap cycle (load_valid=0) holds the count.
  - On the LOADBEATS-th beat → PROC, with itr=0, layer=0, addr=0.
- PROC: rd_en=1, rd_address=addr, rd_layer=layer, one address per cycle.
  - When addr=ROWDEPTH-1 → DRAIN.
- Write side: {rd_en, rd_address, rd_layer} delayed exactly PIPESTAGES cycles gives {wr_en, wr_address, wr_layer}. The delay line keeps shifting in every state.
- DRAIN: rd_en=0 (layer hazard stall) until the last write of the layer has issued (wr_en=1 with wr_address=ROWDEPTH-1). Then:
  - If layer<LAYERS-1: layer+1, addr=0 → PROC.
  - Else it is iteration end:
    - If early_term=1, or itr+1==lim → UNLOAD.
    - Otherwise itr+1, layer=0 → PROC.
- Timing: a layer takes ROWDEPTH+PIPESTAGES = 35 cycles and an iteration takes 70 cycles. The first read of the next layer occurs the cycle after the last write.
- firstprocessing_indicate = 1 from PROC entry while itr==0, including the iteration-0 write tail. It drops the cycle itr becomes 1.
- UNLOAD: unload_en=1, unloadAddress 0..UNLOADDEPTH-1, one per cycle → DONE.
- DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- itr holds its final value until the next accepted start.
- Simultaneous events: early_term outside the iteration-end cycle is ignored. load_valid outside LOAD is ignored.

Test Plan:
- Reset mid-PROC (rst low at cycle 30 of iteration 2) → all outputs 0 immediately. start then decodes normally from LOAD.
- Nominal run (start, max_itr=2, 17 back-to-back beats):
  - 17 loaden cycles.
  - rd_en pattern: 20 on / 15 off ×4.
  - wr_en equals rd_en shifted exactly 15 cycles, with matching address/layer.
  - firstprocessing_indicate high for exactly 70 cycles.
  - 16 unload cycles, addresses 0..15; then done pulse; itr=1.
- Load gaps: load_valid toggles 1,0,… → exactly 17 loaden pulses. PROC begins the cycle after the 17th beat.
- early_term=1 at end of iteration 0, with max_itr=10 → UNLOAD after 70 PROC/DRAIN cycles; itr=0.
- max_itr=0 → 1 iteration. max_itr=15 → clamped to 10 iterations (700 cycles).
- start pulsed during PROC/UNLOAD → ignored; a single done pulse only.
